// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad sequencer for the two-digit calculator.
// Collects A, operator and B as BCD digits, computes A+B or A-B, and
// converts the result to hundreds/tens/units with a repeated-subtraction
// loop. It then drives the display decoder from registered outputs.
module calc_sequencer #(
    parameter logic [3:0] CODE_ADD = 4'd10,
    parameter logic [3:0] CODE_SUB = 4'd11,
    parameter logic [3:0] CODE_EQ  = 4'd12,
    parameter logic [3:0] CODE_CLR = 4'd13
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KeyValid,
    input  logic [3:0] KeyCode,
    output logic [1:0] state,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_ENTRY_A = 2'b00,
        ST_ENTRY_B = 2'b01,
        ST_CALC    = 2'b10,
        ST_RESULT  = 2'b11
    } state_t;

    state_t state_q, state_d;

    // Operands as BCD digit pairs, operator (1 = subtract)
    logic [3:0] a_tens_q, a_tens_d, a_units_q, a_units_d;
    logic [3:0] b_tens_q, b_tens_d, b_units_q, b_units_d;
    logic       op_sub_q, op_sub_d;

    // Conversion working registers
    logic signed [8:0] r_q, r_d;
    logic [1:0]        h_q, h_d;
    logic [3:0]        t_q, t_d;
    logic              calc_init_q, calc_init_d;

    // Registered display outputs
    logic [3:0] units_q, units_d, tens_q, tens_d;
    logic [1:0] hund_q, hund_d;
    logic       zero_q, zero_d, ovf_q, ovf_d, busy_q, busy_d;

    // Decoded key classes
    logic key_digit, key_op, key_eq, key_clr;
    logic signed [8:0] calc_val;

    // Binary value of a two-digit BCD operand
    function automatic logic signed [8:0] bcd_val(input logic [3:0] tens,
                                                  input logic [3:0] units);
        logic [8:0] v;
        v = ({5'd0, tens} * 9'd10) + {5'd0, units};
        return $signed(v);
    endfunction

    // Sum or difference of the two operands
    function automatic logic signed [8:0] arith(input logic [3:0] at,
                                                input logic [3:0] au,
                                                input logic [3:0] bt,
                                                input logic [3:0] bu,
                                                input logic       sub);
        if (sub) begin
            return bcd_val(at, au) - bcd_val(bt, bu);
        end
        return bcd_val(at, au) + bcd_val(bt, bu);
    endfunction

    // Key decode
    always_comb begin
        key_digit = KeyValid && (KeyCode <= 4'd9);
        key_op    = KeyValid && ((KeyCode == CODE_ADD) || (KeyCode == CODE_SUB));
        key_eq    = KeyValid && (KeyCode == CODE_EQ);
        key_clr   = KeyValid && (KeyCode == CODE_CLR);
        calc_val  = arith(a_tens_q, a_units_q, b_tens_q, b_units_q, op_sub_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        a_tens_d    = a_tens_q;
        a_units_d   = a_units_q;
        b_tens_d    = b_tens_q;
        b_units_d   = b_units_q;
        op_sub_d    = op_sub_q;
        r_d         = r_q;
        h_d         = h_q;
        t_d         = t_q;
        calc_init_d = 1'b0;
        units_d     = units_q;
        tens_d      = tens_q;
        hund_d      = hund_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_ENTRY_A: begin
                if (key_digit) begin
                    // Shift in only while the tens slot is still empty
                    if (a_tens_q == 4'd0) begin
                        a_tens_d  = a_units_q;
                        a_units_d = KeyCode;
                        tens_d    = a_units_q;
                        units_d   = KeyCode;
                        zero_d    = (a_units_q == 4'd0) && (KeyCode == 4'd0);
                    end
                end else if (key_op) begin
                    op_sub_d  = (KeyCode == CODE_SUB);
                    b_tens_d  = 4'd0;
                    b_units_d = 4'd0;
                    state_d   = ST_ENTRY_B;
                    units_d   = 4'd0;
                    tens_d    = 4'd0;
                    zero_d    = 1'b1;
                end
            end

            ST_ENTRY_B: begin
                if (key_digit) begin
                    if (b_tens_q == 4'd0) begin
                        b_tens_d  = b_units_q;
                        b_units_d = KeyCode;
                        tens_d    = b_units_q;
                        units_d   = KeyCode;
                        zero_d    = (b_units_q == 4'd0) && (KeyCode == 4'd0);
                    end
                end else if (key_op) begin
                    op_sub_d = (KeyCode == CODE_SUB);
                end else if (key_eq) begin
                    state_d     = ST_CALC;
                    calc_init_d = 1'b1;
                end
            end

            ST_CALC: begin
                if (calc_init_q) begin
                    // First cycle: form R; a negative result finishes at once
                    h_d = 2'd0;
                    t_d = 4'd0;
                    r_d = calc_val;
                    if (calc_val < 9'sd0) begin
                        state_d = ST_RESULT;
                        units_d = 4'd0;
                        tens_d  = 4'd0;
                        hund_d  = 2'd0;
                        zero_d  = 1'b0;
                        ovf_d   = 1'b1;
                    end
                end else if (r_q >= 9'sd100) begin
                    r_d = r_q - 9'sd100;
                    h_d = h_q + 2'd1;
                end else if (r_q >= 9'sd10) begin
                    r_d = r_q - 9'sd10;
                    t_d = t_q + 4'd1;
                end else begin
                    // Remainder is the units digit; commit to the display
                    state_d = ST_RESULT;
                    units_d = r_q[3:0];
                    tens_d  = t_q;
                    hund_d  = h_q;
                    ovf_d   = 1'b0;
                    zero_d  = (h_q == 2'd0) && (t_q == 4'd0) && (r_q[3:0] == 4'd0);
                end
            end

            ST_RESULT: begin
                if (key_digit) begin
                    // A fresh digit starts a new calculation
                    a_tens_d  = 4'd0;
                    a_units_d = KeyCode;
                    b_tens_d  = 4'd0;
                    b_units_d = 4'd0;
                    state_d   = ST_ENTRY_A;
                    units_d   = KeyCode;
                    tens_d    = 4'd0;
                    hund_d    = 2'd0;
                    ovf_d     = 1'b0;
                    zero_d    = (KeyCode == 4'd0);
                end else if (key_op && !ovf_q && (hund_q == 2'd0)) begin
                    // Chain: a two-digit result becomes operand A
                    a_tens_d  = tens_q;
                    a_units_d = units_q;
                    op_sub_d  = (KeyCode == CODE_SUB);
                    b_tens_d  = 4'd0;
                    b_units_d = 4'd0;
                    state_d   = ST_ENTRY_B;
                    units_d   = 4'd0;
                    tens_d    = 4'd0;
                    zero_d    = 1'b1;
                end
            end

            default: state_d = ST_ENTRY_A;
        endcase

        // Clear behaves like reset everywhere except during conversion
        if (key_clr && (state_q != ST_CALC)) begin
            state_d   = ST_ENTRY_A;
            a_tens_d  = 4'd0;
            a_units_d = 4'd0;
            b_tens_d  = 4'd0;
            b_units_d = 4'd0;
            op_sub_d  = 1'b0;
            units_d   = 4'd0;
            tens_d    = 4'd0;
            hund_d    = 2'd0;
            zero_d    = 1'b1;
            ovf_d     = 1'b0;
        end

        busy_d = (state_d == ST_CALC);
    end

    // State, operand, working and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_ENTRY_A;
            a_tens_q    <= 4'd0;
            a_units_q   <= 4'd0;
            b_tens_q    <= 4'd0;
            b_units_q   <= 4'd0;
            op_sub_q    <= 1'b0;
            r_q         <= 9'sd0;
            h_q         <= 2'd0;
            t_q         <= 4'd0;
            calc_init_q <= 1'b0;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            hund_q      <= 2'd0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_tens_q    <= a_tens_d;
            a_units_q   <= a_units_d;
            b_tens_q    <= b_tens_d;
            b_units_q   <= b_units_d;
            op_sub_q    <= op_sub_d;
            r_q         <= r_d;
            h_q         <= h_d;
            t_q         <= t_d;
            calc_init_q <= calc_init_d;
            units_q     <= units_d;
            tens_q      <= tens_d;
            hund_q      <= hund_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign state    = state_q;
    assign Units    = units_q;
    assign Tens     = tens_q;
    assign Hundreds = hund_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign Busy     = busy_q;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Keypad-driven controller for the two-digit calculator. It collects operand A, the operator and operand B, then computes A+B or A−B. It converts the result to BCD with a multi-cycle repeated-subtraction loop and drives the display decoder's state, Units, Tens, Hundreds, Zero and Overflow inputs. While operands are entered, the display shows the operand being typed.

Parameters:
CODE_ADD, 4'd10, KeyCode for "+"
CODE_SUB, 4'd11, KeyCode for "−"
CODE_EQ, 4'd12, KeyCode for "="
CODE_CLR, 4'd13, KeyCode for clear

Ports:
Clock  in  1  system clock; all registers update on its rising edge
Reset  in  1  synchronous, active-high reset
KeyValid  in  1  single-cycle strobe; KeyCode is valid in this cycle
KeyCode  in  4  0–9 = digit; 10–13 = operator/control codes per parameters; 14–15 ignored
state  out  2  FSM state to the display decoder: 00 ENTRY_A, 01 ENTRY_B, 10 CALC, 11 RESULT
Units  out  4  BCD units digit shown
Tens  out  4  BCD tens digit shown
Hundreds  out  2  hundreds digit shown (0–2)
Zero  out  1  shown value equals 0
Overflow  out  1  result negative; decoder shows error pattern
Busy  out  1  high in CALC; keys are ignored

Behaviour:
- Reset (has priority over KeyValid in the same cycle): state=ENTRY_A; Units=Tens=0; Hundreds=0; Zero=1; Overflow=0; Busy=0; operands and operator cleared (operator=ADD).
- All outputs are registered. A key accepted at edge n is visible on the outputs after edge n.
- Operands are held as two BCD digits. Digit entry: if the current operand tens digit is 0, shift left (tens←units, units←digit); otherwise the key is ignored. Maximum operand is 99; a third digit is dropped.
- Leading zeros shift out harmlessly: "0","5" gives 05.
- ENTRY_A:
  - digit → update A; display A
  - ADD/SUB → latch operator, clear B, go to ENTRY_B; display 00
  - EQ → ignored
- ENTRY_B:
  - digit → update B; display B
  - ADD/SUB → replace operator only
  - EQ → go to CALC
- CLR in ENTRY_A, ENTRY_B or RESULT → same state as reset. CLR in CALC is ignored.
- CALC (Busy=1, all keys ignored, Units/Tens/Hundreds/Zero/Overflow hold previous values):
  - cycle 0: R = A+B or A−B, using binary values A=10·tens+units, width 9 bits signed. If R<0, set working Overflow flag and go directly to RESULT next.
  - each following cycle, exactly one step:
    - R≥100: R−=100, h++
    - else R≥10: R−=10, t++
    - else: u=R, commit, go to RESULT
  - Cycles spent in CALC = 2 + h + t for a non-negative result; 1 cycle for a negative result.
- RESULT: outputs committed from h/t/u.
  - Overflow=1 → Units=Tens=Hundreds=0, Zero=0.
  - Zero=1 iff h=t=u=0 and no Overflow.
  - Key handling in RESULT:
    - digit → clear A and B, A.units=digit, go to ENTRY_A
    - ADD/SUB with Overflow=0 and h=0 → A={t,u}, latch operator, clear B, go to ENTRY_B (chaining)
    - ADD/SUB with h≠0 or Overflow=1 → ignored
    - EQ → ignored
- Zero in the ENTRY states = 1 iff the shown operand is 00.
- Reset asserted in CALC aborts the conversion immediately; no partial result is committed.
- KeyValid held high for several cycles is treated as one key per cycle. Upstream debounce guarantees single pulses.

Test Plan:
- Reset, then keys 4,7,+,5,8,= → state goes 10 for exactly 3 cycles (1 setup + h=1 + t=0 + 1 commit), then 11. Hundreds=1, Tens=0, Units=5, Zero=0, Overflow=0.
- Keys 9,9,+,9,9,= → CALC lasts 12 cycles; Busy=1 throughout, and a digit key injected mid-CALC has no effect. Result 1/9/8.
- Keys 2,5,−,3,0,= → CALC lasts 1 cycle; RESULT with Overflow=1, Units=Tens=Hundreds=0, Zero=0.
- Keys 1,2,3 → display Tens=1, Units=2 (3 dropped). Then CLR → ENTRY_A, display 00, Zero=1.
- Keys 7,−,7,= → result 0: Zero=1. Then + → ENTRY_B with A=00. Then 4,= → result 4.
- Reset asserted during CALC in the same cycle as KeyValid with a digit → state=00, all outputs at reset values, key discarded.
